// File: rtl/pipe_pkg.sv
// Shared pipeline widths and MEM-stage FSM state encoding.
package pipe_pkg;
   localparam int WORD_W     = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic {IDLE, BUSY} mem_state_e;
endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// Latency: write lands on the clock edge, read is combinational; no flow control.
module data_mem
   import pipe_pkg::*;
#(
   parameter int WORDS = 256
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(WORDS)-1:0] addr,
   input  logic [WORD_W-1:0]        wdata,
   output logic [WORD_W-1:0]        rdata
);

   logic [WORD_W-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: lw/sw against data_mem, MW_* pipeline register, branch redirect.
// Latency: MEM_LAT edges per aligned access (mem_stall holds upstream), 1 edge otherwise.
module memory_stage
   import pipe_pkg::*;
#(
   parameter int DMEM_WORDS = 256,
   parameter int MEM_LAT    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  XM_MemtoReg,
   input  logic                  XM_RegWrite,
   input  logic                  XM_MemRead,
   input  logic                  XM_MemWrite,
   input  logic                  XM_branch,
   input  logic [WORD_W-1:0]     ALUout,
   input  logic [REG_ADDR_W-1:0] XM_RD,
   input  logic [WORD_W-1:0]     XM_MD,
   input  logic [WORD_W-1:0]     XM_BT,
   output logic                  MW_MemtoReg,
   output logic                  MW_RegWrite,
   output logic [WORD_W-1:0]     MW_ALUout,
   output logic [WORD_W-1:0]     MW_MDR,
   output logic [REG_ADDR_W-1:0] MW_RD,
   output logic                  branch_taken,
   output logic [WORD_W-1:0]     branch_target,
   output logic                  mem_stall,
   output logic                  misalign_err
);

   localparam int AW = $clog2(DMEM_WORDS);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

   mem_state_e        state;
   logic [CW-1:0]     cnt;
   logic              mem_op, aligned, req, misalign, done;
   logic [AW-1:0]     idx;
   logic [WORD_W-1:0] rdata;
   logic              unused_addr_hi;

   assign mem_op    = XM_MemRead | XM_MemWrite;
   assign aligned   = (ALUout[1:0] == 2'b00);
   assign req       = mem_op & aligned;
   assign misalign  = mem_op & ~aligned;
   // Upper address bits are dropped, so the memory aliases modulo its depth.
   assign idx            = ALUout[AW+1:2];
   assign unused_addr_hi = &{1'b0, ALUout[WORD_W-1:AW+2]};

   assign mem_stall     = req & (cnt != LAST);
   assign done          = req & ~mem_stall;
   assign branch_taken  = XM_branch;
   assign branch_target = XM_BT;

   // Gating with rst drops a store whose completion coincides with reset.
   data_mem #(.WORDS(DMEM_WORDS)) u_dmem (
      .clk   (clk),
      .we    (done & XM_MemWrite & ~rst),
      .addr  (idx),
      .wdata (XM_MD),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         MW_MemtoReg  <= 1'b0;
         MW_RegWrite  <= 1'b0;
         MW_ALUout    <= '0;
         MW_MDR       <= '0;
         MW_RD        <= '0;
         misalign_err <= 1'b0;
      end else begin
         if (state == IDLE) begin
            if (mem_stall) begin
               state <= BUSY;
               cnt   <= CW'(1);
            end
         end else if (!req || cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end

         if (mem_stall) begin
            MW_RegWrite <= 1'b0;
            MW_MemtoReg <= 1'b0;
         end else begin
            MW_RegWrite <= XM_RegWrite & ~misalign;
            MW_MemtoReg <= XM_MemtoReg;
            MW_ALUout   <= ALUout;
            MW_RD       <= XM_RD;
            // Read-and-write together returns the word as it was before the store.
            if (done && XM_MemRead) MW_MDR <= rdata;
         end

         if (misalign) misalign_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Bench: drives a MEM_LAT=1 and a MEM_LAT=3 memory_stage with directed steps,
// predicts MW_* from a reference memory model and checks them through a scoreboard queue.
module tb_memory_stage;
   import pipe_pkg::*;

   typedef struct packed {
      logic        mtr, rw, mr, mw, br;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic [31:0] md, bt;
   } xm_t;

   typedef struct packed {
      logic        rw, mtr;
      logic [31:0] alu, mdr;
      logic [4:0]  rd;
   } mw_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   xm_t x1, x3;
   logic [1:0]       mtr_o, rw_o, bt_taken_o, stall_o, err_o;
   logic [1:0][31:0] alu_o, mdr_o, bt_o;
   logic [1:0][4:0]  rd_o;

   memory_stage #(.DMEM_WORDS(256), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
      .XM_MemtoReg(x1.mtr), .XM_RegWrite(x1.rw), .XM_MemRead(x1.mr), .XM_MemWrite(x1.mw),
      .XM_branch(x1.br), .ALUout(x1.alu), .XM_RD(x1.rd), .XM_MD(x1.md), .XM_BT(x1.bt),
      .MW_MemtoReg(mtr_o[0]), .MW_RegWrite(rw_o[0]), .MW_ALUout(alu_o[0]), .MW_MDR(mdr_o[0]),
      .MW_RD(rd_o[0]), .branch_taken(bt_taken_o[0]), .branch_target(bt_o[0]),
      .mem_stall(stall_o[0]), .misalign_err(err_o[0])
   );

   memory_stage #(.DMEM_WORDS(256), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst(rst),
      .XM_MemtoReg(x3.mtr), .XM_RegWrite(x3.rw), .XM_MemRead(x3.mr), .XM_MemWrite(x3.mw),
      .XM_branch(x3.br), .ALUout(x3.alu), .XM_RD(x3.rd), .XM_MD(x3.md), .XM_BT(x3.bt),
      .MW_MemtoReg(mtr_o[1]), .MW_RegWrite(rw_o[1]), .MW_ALUout(alu_o[1]), .MW_MDR(mdr_o[1]),
      .MW_RD(rd_o[1]), .branch_taken(bt_taken_o[1]), .branch_target(bt_o[1]),
      .mem_stall(stall_o[1]), .misalign_err(err_o[1])
   );

   int passed = 0;
   int failed = 0;
   int total  = 0;
   int s      = 0;
   int lat [2] = '{1, 3};

   logic [31:0] mm [2][256];
   logic [31:0] emdr [2];
   logic        eerr [2];
   mw_t         sbq [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic xm_t mk(input logic mr, mw, rw, mtr, input logic [31:0] alu,
                              input logic [4:0] rd, input logic [31:0] md);
      xm_t x;
      x = '0;
      x.mr = mr; x.mw = mw; x.rw = rw; x.mtr = mtr;
      x.alu = alu; x.rd = rd; x.md = md;
      return x;
   endfunction

   task automatic drive(input xm_t x);
      if (s == 0) x1 = x;
      else        x3 = x;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rw"},    rw_o[s],    0);
      chk({tag, "_mtr"},   mtr_o[s],   0);
      chk({tag, "_alu"},   alu_o[s],   0);
      chk({tag, "_mdr"},   mdr_o[s],   0);
      chk({tag, "_rd"},    rd_o[s],    0);
      chk({tag, "_err"},   err_o[s],   0);
      chk({tag, "_stall"}, stall_o[s], 0);
   endtask

   // Predict the instruction's MW_* result, then step it through its stall cycles.
   task automatic issue(input string tag, input xm_t x);
      mw_t        e, g;
      logic       mem_op, req;
      logic [7:0] ix;
      int         ns;
      @(negedge clk);
      drive(x);
      mem_op = x.mr | x.mw;
      req    = mem_op && (x.alu[1:0] == 2'b00);
      ix     = x.alu[9:2];
      if (mem_op && !req) eerr[s] = 1'b1;
      e.rw  = x.rw & ~(mem_op & ~req);
      e.mtr = x.mtr;
      e.alu = x.alu;
      e.rd  = x.rd;
      if (req && x.mr) emdr[s] = mm[s][ix];
      e.mdr = emdr[s];
      if (req && x.mw) mm[s][ix] = x.md;
      sbq.push_back(e);
      ns = req ? lat[s] - 1 : 0;
      #1;
      chk({tag, "_br"},  bt_taken_o[s], x.br);
      chk({tag, "_bt"},  bt_o[s],       x.bt);
      for (int c = 0; c < ns; c++) begin
         chk({tag, "_stall_hi"}, stall_o[s], 1);
         @(posedge clk); #1;
         chk({tag, "_bub_rw"},  rw_o[s],  0);
         chk({tag, "_bub_mtr"}, mtr_o[s], 0);
      end
      chk({tag, "_stall_lo"}, stall_o[s], 0);
      @(posedge clk); #1;
      chk({tag, "_sb_avail"}, sbq.size(), 1);
      if (sbq.size() != 0) begin
         g = sbq.pop_front();
         chk({tag, "_rw"},  rw_o[s],  g.rw);
         chk({tag, "_mtr"}, mtr_o[s], g.mtr);
         chk({tag, "_alu"}, alu_o[s], g.alu);
         chk({tag, "_mdr"}, mdr_o[s], g.mdr);
         chk({tag, "_rd"},  rd_o[s],  g.rd);
      end
      chk({tag, "_err"}, err_o[s], eerr[s]);
   endtask

   initial begin
      xm_t xb;
      rst = 1'b1;
      x1  = '0;
      x3  = '0;
      emdr = '{32'h0, 32'h0};
      eerr = '{1'b0, 1'b0};
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         s = k;
         check_zero("reset");
      end

      s = 0;
      issue("sw10",   mk(0, 1, 0, 0, 32'h10,  0,  32'hDEADBEEF));
      issue("lw10",   mk(1, 0, 1, 1, 32'h10,  8,  32'h0));
      issue("alu",    mk(0, 0, 1, 0, 32'h1234, 3, 32'h0));
      issue("sw20",   mk(0, 1, 0, 0, 32'h20,  0,  32'hA5A5A5A5));
      issue("sw22",   mk(0, 1, 1, 0, 32'h22,  0,  32'h0BADBAD0));
      issue("lw20",   mk(1, 0, 1, 1, 32'h20,  9,  32'h0));
      issue("lw21",   mk(1, 0, 1, 1, 32'h21,  4,  32'h0));
      issue("sw400",  mk(0, 1, 0, 0, 32'h400, 0,  32'hCAFEF00D));
      issue("lw000",  mk(1, 0, 1, 1, 32'h000, 10, 32'h0));
      issue("rdwr10", mk(1, 1, 1, 1, 32'h10,  11, 32'h12345678));
      issue("lw10b",  mk(1, 0, 1, 1, 32'h10,  12, 32'h0));
      xb = mk(0, 0, 0, 0, 32'h77, 0, 32'h0);
      xb.br = 1'b1;
      xb.bt = 32'h40;
      issue("branch", xb);
      @(negedge clk);
      x1 = '0;

      s = 1;
      issue("l3_sw20",  mk(0, 1, 0, 0, 32'h20, 0,  32'h0F0F0F0F));
      issue("l3_lw20",  mk(1, 0, 1, 1, 32'h20, 5,  32'h0));
      issue("l3_sw20b", mk(0, 1, 0, 0, 32'h20, 0,  32'h76543210));
      issue("l3_alu",   mk(0, 0, 1, 0, 32'hABC, 7, 32'h0));
      issue("l3_lw20b", mk(1, 0, 1, 1, 32'h20, 6,  32'h0));
      issue("l3_sw30",  mk(0, 1, 0, 0, 32'h30, 0,  32'h11111111));

      // Reset lands while a store to 0x30 is still in flight.
      @(negedge clk);
      x3 = mk(0, 1, 0, 0, 32'h30, 0, 32'h99999999);
      #1;
      chk("rst_busy_stall0", stall_o[1], 1);
      @(posedge clk); #1;
      chk("rst_busy_stall1", stall_o[1], 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0;
      x3 = '0;
      emdr[1] = '0;
      eerr[1] = 1'b0;
      #1;
      check_zero("rst_busy");
      issue("l3_lw30",  mk(1, 0, 1, 1, 32'h30, 13, 32'h0));
      issue("l3_sw22",  mk(0, 1, 0, 0, 32'h22, 0,  32'hFFFFFFFF));
      issue("l3_lw20c", mk(1, 0, 1, 1, 32'h20, 14, 32'h0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
